// File: rtl/adder_result_if.sv
// Result-word channel between the 16-bit adder/subtractor, the result buffer and its consumer.
// Handshake: a word moves on a rising edge where valid & ready are both 1; ready never depends on valid.
interface adder_result_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_c_out;
  logic        in_o;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;

  modport slave (
    input  in_valid, in_sum, in_c_out, in_o, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_sum, in_c_out, in_o, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/adder_result_buffer.sv
// First-word-fall-through FIFO for adder result words {O, C_out, SUM},
// plus a sticky overflow flag and a saturating overflow event counter.
module adder_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adder_result_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  logic                   stat_clr,
  output logic                   ovf_sticky,
  output logic [CNT_W-1:0]       ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  logic          ovf_event;

  // Flags decode from the registered count only, so ready/valid never see in_valid or out_ready.
  always_comb begin
    full          = (count_q == DEPTH_C);
    empty         = (count_q == '0);
    count         = count_q;
    bus.in_ready  = !full;
    bus.out_valid = !empty;
    bus.out_data  = empty ? 18'h0 : mem[rd_ptr];
    push          = bus.in_valid & !full;
    pop           = !empty & bus.out_ready;
    ovf_event     = push & bus.in_o;
  end

  // Storage is deliberately left out of reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_o, bus.in_c_out, bus.in_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // An accepted overflow word in the same cycle as stat_clr wins: the count restarts at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_event) begin
      ovf_sticky <= 1'b1;
      if (stat_clr) begin
        ovf_cnt <= CNT_W'(1);
      end else if (ovf_cnt != CNT_MAX) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end else if (stat_clr) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end
  end
endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer: a scoreboard queue filled by the driver
// and drained by an independent output monitor, plus direct status checks.
module tb_adder_result_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stat_clr;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf_sticky;
  logic [15:0] ovf_cnt;
  logic [3:0]  count4;
  logic        full4;
  logic        empty4;
  logic        ovf_sticky4;
  logic [3:0]  ovf_cnt4;

  adder_result_if bus ();
  adder_result_if bus4 ();

  // The narrow-counter instance sees exactly the same stimulus as the main one.
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_sum    = bus.in_sum;
  assign bus4.in_c_out  = bus.in_c_out;
  assign bus4.in_o      = bus.in_o;
  assign bus4.out_ready = bus.out_ready;

  adder_result_buffer #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .count(count), .full(full),
    .empty(empty), .stat_clr(stat_clr), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );

  adder_result_buffer #(.DEPTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .count(count4), .full(full4),
    .empty(empty4), .stat_clr(stat_clr), .ovf_sticky(ovf_sticky4), .ovf_cnt(ovf_cnt4)
  );

  int          tests = 0;
  int          fails = 0;
  logic [17:0] exp_q[$];
  logic        last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every word the consumer takes must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_word: got %h expected no word", bus.out_data);
      end else begin
        logic [17:0] exp_w;
        exp_w = exp_q.pop_front();
        if (bus.out_data !== exp_w) begin
          fails++;
          $display("FAIL out_word: got %h expected %h", bus.out_data, exp_w);
        end
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [15:0] sum, input logic c, input logic o,
                       input logic rdy, input logic clr);
    bus.in_valid  = v;
    bus.in_sum    = sum;
    bus.in_c_out  = c;
    bus.in_o      = o;
    bus.out_ready = rdy;
    stat_clr      = clr;
    @(negedge clk);
    last_acc = rst_n && v && bus.in_ready;
    if (last_acc) exp_q.push_back({o, c, sum});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && count != 0; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(count), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    stat_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_c_out = 1'b0; bus.in_o = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;

    // Reset mid-operation discards stored words and statistics.
    cycle(1'b1, 16'hAAA1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'hAAA2, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'hAAA3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    idle(2);
    exp_q.delete();
    rst_n = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // One-cycle latency from push into an empty buffer.
    check("lat_before", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_out_data", 32'(bus.out_data), 32'h11234);
    check("lat_count", 32'(count), 32'd1);
    drain();

    // Fill to full, hold a ninth word, then drain.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_flag", 32'(full), 32'd1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_count", 32'(count), 32'd8);
    cycle(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_count", 32'(count), 32'd8);
    cycle(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0);
    check("held_not_taken", 32'(last_acc), 32'd0);
    check("pop_from_full", 32'(count), 32'd7);
    for (int i = 0; i < 5 && !last_acc; i++) cycle(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ninth_accepted", 32'(last_acc), 32'd1);
    drain();

    // Steady push&pop at count=3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) begin
      cycle(1'b1, 16'hA000 + 16'(i), 1'(i % 2), 1'b0, 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd3);
    end
    drain();

    // Overflow statistics and the clear-versus-event priority.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'h5005, 1'b1, 1'b0, 1'b1, 1'b0);
    check("stat_cnt5", 32'(ovf_cnt), 32'd5);
    check("stat_sticky", 32'(ovf_sticky), 32'd1);
    check("stat_cnt5_narrow", 32'(ovf_cnt4), 32'd5);
    cycle(1'b1, 16'h5006, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_event_cnt", 32'(ovf_cnt), 32'd1);
    check("clr_event_sticky", 32'(ovf_sticky), 32'd1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_cnt", 32'(ovf_cnt), 32'd0);
    check("clr_sticky", 32'(ovf_sticky), 32'd0);
    drain();

    // Saturation of the 4-bit counter; refused words never count.
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_narrow", 32'(ovf_cnt4), 32'hF);
    check("sat_wide", 32'(ovf_cnt), 32'd20);
    drain();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("full_no_count", 32'(ovf_cnt), 32'd20);
    check("full_no_count_narrow", 32'(ovf_cnt4), 32'hF);
    check("full_refused", 32'(count), 32'd8);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
